bnn_init_seq: RTL and testbench
===============================

BNN_INIT_SEQ -- requirements
Module: bnn_init_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles all outputs stay in reset after reset release (legal range >= 1).
REQ-002 Parameter MEM_DEPTH, default 98: number of activation-buffer words to clear (legal range >= 1).
REQ-003 Parameter N_STAGES, default 3: number of downstream stage resets released in order (legal range >= 1).
REQ-004 Derived constant ADDR_W = max(1, clog2(MEM_DEPTH)).
REQ-005 Port clk, input, 1: single clock; all state is on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset, driven from the synchronized reset output of the reset synchronizer.
REQ-007 Port soft_init, input, 1: request to re-run the init sequence without a hard reset.
REQ-008 Port clr_we, output, 1: write-enable for the zero-write into the activation buffer.
REQ-009 Port clr_addr, output, ADDR_W: address of the word being cleared.
REQ-010 Port stage_rst_n, output, N_STAGES: active-low per-stage resets; bit 0 is the first stage released.
REQ-011 Port init_done, output, 1: high once the full sequence has completed.

Function
REQ-012 FSM states SHALL be HOLD, CLEAR, RELEASE and DONE; one shared counter serves all phases.
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 Timeline, with edge 1 = first rising clk edge with rst_n high: HOLD occupies edges 1..HOLD_CYCLES with clr_we=0, stage_rst_n all 0 and init_done=0.
REQ-015 CLEAR: after edge H=HOLD_CYCLES, clr_we=1 and clr_addr=0; clr_addr increments by 1 each edge; clr_we stays high for exactly MEM_DEPTH cycles, ending with clr_addr=MEM_DEPTH-1.
REQ-016 RELEASE: at edge H+MEM_DEPTH, clr_we goes 0 and stage_rst_n[0] goes 1; at edge H+MEM_DEPTH+i, stage_rst_n[i] goes 1; released bits stay 1.
REQ-017 DONE: init_done goes 1 on the same edge as stage_rst_n[N_STAGES-1], then holds until the next reset or soft_init.
REQ-018 clr_addr SHALL be 0 whenever clr_we=0, and SHALL never exceed MEM_DEPTH-1; it does not wrap.
REQ-019 soft_init high at an edge while in DONE: on that edge stage_rst_n goes all 0, init_done goes 0 and the state goes to HOLD; the timeline of REQ-014..017 then restarts with that edge as edge 0.
REQ-020 soft_init SHALL be ignored in HOLD, CLEAR and RELEASE; a pending request is not latched.
REQ-021 soft_init held continuously high SHALL retrigger once per completed sequence, one cycle after init_done rises.

Reset
REQ-022 rst_n low SHALL immediately and asynchronously force state=HOLD, counter=0, clr_we=0, clr_addr=0, stage_rst_n=all 0 and init_done=0.
REQ-023 Reset asserted mid-CLEAR or mid-RELEASE SHALL abort the sequence with no further clear writes; after release the full sequence restarts from HOLD.
REQ-024 Reset SHALL take priority over soft_init on every edge.

Structure
REQ-025 The FSM state enum and the default values of HOLD_CYCLES, MEM_DEPTH and N_STAGES SHALL live in the shared package bnn_pkg.
REQ-026 The block SHALL be a single module with no sub-modules; the counter is inline.

Verification (use HOLD_CYCLES=2, MEM_DEPTH=4, N_STAGES=3)
REQ-027 Reset release -> clr_we=1 after edges 2..5 with clr_addr 0,1,2,3; stage_rst_n = 001 at edge 6, 011 at edge 7, 111 at edge 8; init_done=1 at edge 8.
REQ-028 rst_n driven low 1 ns after edge 4 (mid-CLEAR) -> all outputs 0 within 1 ns; after re-release, the full REQ-027 timeline repeats exactly.
REQ-029 In DONE, soft_init pulsed for one cycle -> same edge gives stage_rst_n=000 and init_done=0; clr_we high at relative edges 2..5; init_done at relative edge 8.
REQ-030 soft_init pulsed during CLEAR and again during RELEASE -> no change to the REQ-027 timeline.
REQ-031 soft_init held high for 30 cycles -> init_done pulses for exactly 1 cycle per sequence, and the sequence restarts every 9 cycles.
REQ-032 Default parameters -> exactly 98 clr_we cycles, addresses 0..97 each written once, and init_done at edge 104.

Source files
------------

// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN accelerator init sequencer:
//   - bnn_state_e : sequencer FSM state encoding
//   - *_DEF       : default sizing of the init sequence
//   - max_int     : elaboration-time helper for width derivation
// -----------------------------------------------------------------------------
package bnn_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } bnn_state_e;

   localparam int HOLD_CYCLES_DEF = 4;
   localparam int MEM_DEPTH_DEF   = 98;
   localparam int N_STAGES_DEF    = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bnn_init_seq.sv
// -----------------------------------------------------------------------------
// bnn_init_seq
// Post-reset initialisation sequencer for the BNN datapath. After reset it
// holds everything in reset for HOLD_CYCLES, zero-fills the activation buffer
// (MEM_DEPTH words), then releases N_STAGES downstream stage resets one per
// cycle in order and flags completion. soft_init re-runs the sequence once
// the previous one has completed.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   rst_n        in   async active-low reset (already synchronised upstream)
//   soft_init    in   re-run request, honoured only in DONE
//   clr_we       out  zero-write enable into the activation buffer
//   clr_addr     out  address of the word being cleared (0 when clr_we=0)
//   stage_rst_n  out  active-low per-stage resets, bit 0 released first
//   init_done    out  high once the whole sequence has completed
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_HOLD    | all outputs held in reset for HOLD_CYCLES edges
// ST_CLEAR   | clr_we high, clr_addr sweeping 0..MEM_DEPTH-1
// ST_RELEASE | stage resets released one per edge, r_cnt = next stage index
// ST_DONE    | all stages out of reset, init_done high, waits for soft_init
// -----------------------------------------------------------------------------
module bnn_init_seq
   import bnn_pkg::*;
#(
   parameter int  HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int  MEM_DEPTH   = MEM_DEPTH_DEF,
   parameter int  N_STAGES    = N_STAGES_DEF,
   localparam int ADDR_W      = max_int(1, $clog2(MEM_DEPTH))
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                soft_init,
   output logic                clr_we,
   output logic [ADDR_W-1:0]   clr_addr,
   output logic [N_STAGES-1:0] stage_rst_n,
   output logic                init_done
);

   // One counter is shared by all phases, so it must hold the largest
   // terminal value of any of them.
   localparam int CNT_W = max_int(1, $clog2(max_int(HOLD_CYCLES,
                                            max_int(MEM_DEPTH, N_STAGES))));

   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_TC = CNT_W'(MEM_DEPTH - 1);
   localparam logic [CNT_W-1:0] REL_TC   = CNT_W'(N_STAGES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   bnn_state_e            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_clr_we;
   logic [ADDR_W-1:0]     r_clr_addr;
   logic [N_STAGES-1:0]   r_stage_rst_n;
   logic                  r_init_done;

   logic [N_STAGES-1:0]   w_stage_sel;

   // One-hot select of the stage being released this edge in ST_RELEASE.
   always_comb begin
      w_stage_sel = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_stage_sel[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_HOLD;
         r_cnt         <= '0;
         r_clr_we      <= 1'b0;
         r_clr_addr    <= '0;
         r_stage_rst_n <= '0;
         r_init_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_cnt == HOLD_TC) begin
                  r_state    <= ST_CLEAR;
                  r_cnt      <= '0;
                  r_clr_we   <= 1'b1;
                  r_clr_addr <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_CLEAR: begin
               if (r_cnt == CLEAR_TC) begin
                  // Last word written on the previous cycle; stage 0 comes
                  // out of reset on the same edge clr_we drops.
                  r_clr_we         <= 1'b0;
                  r_clr_addr       <= '0;
                  r_stage_rst_n[0] <= 1'b1;
                  if (N_STAGES == 1) begin
                     r_state     <= ST_DONE;
                     r_init_done <= 1'b1;
                     r_cnt       <= '0;
                  end else begin
                     r_state <= ST_RELEASE;
                     r_cnt   <= CNT_ONE;
                  end
               end else begin
                  r_cnt      <= r_cnt + CNT_ONE;
                  r_clr_addr <= r_clr_addr + ADDR_ONE;
               end
            end

            ST_RELEASE: begin
               r_stage_rst_n <= r_stage_rst_n | w_stage_sel;
               if (r_cnt == REL_TC) begin
                  r_state     <= ST_DONE;
                  r_init_done <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_DONE: begin
               if (soft_init) begin
                  r_state       <= ST_HOLD;
                  r_cnt         <= '0;
                  r_stage_rst_n <= '0;
                  r_init_done   <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_HOLD;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign clr_we      = r_clr_we;
   assign clr_addr    = r_clr_addr;
   assign stage_rst_n = r_stage_rst_n;
   assign init_done   = r_init_done;

endmodule

// File: tb/tb_bnn_init_seq.sv
module tb_bnn_init_seq;

   logic       clk;
   logic       rst_n;
   logic       rst_d;
   logic       soft_init;
   logic       soft_d;

   logic       clr_we;
   logic [1:0] clr_addr;
   logic [2:0] stage_rst_n;
   logic       init_done;

   logic       clr_we_d;
   logic [6:0] clr_addr_d;
   logic [2:0] stage_rst_n_d;
   logic       init_done_d;

   int         n_vec;
   int         n_err;
   int         n_m;
   logic [11:0] sb_q[$];

   bnn_init_seq #(.HOLD_CYCLES(2), .MEM_DEPTH(4), .N_STAGES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .soft_init   (soft_init),
      .clr_we      (clr_we),
      .clr_addr    (clr_addr),
      .stage_rst_n (stage_rst_n),
      .init_done   (init_done)
   );

   bnn_init_seq dut_def (
      .clk         (clk),
      .rst_n       (rst_d),
      .soft_init   (soft_d),
      .clr_we      (clr_we_d),
      .clr_addr    (clr_addr_d),
      .stage_rst_n (stage_rst_n_d),
      .init_done   (init_done_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs n edges into a sequence (edge 0 = reset / restart).
   function automatic logic [11:0] model(input int n, input int h, input int m,
                                         input int ns);
      logic       we;
      logic [6:0] a;
      logic [2:0] st;
      logic       d;
      we = (n >= h) && (n < h + m);
      a  = we ? 7'(n - h) : 7'd0;
      for (int i = 0; i < 3; i++) st[i] = (i < ns) && (n >= h + m + i);
      d  = (n >= h + m + ns - 1);
      return {we, a, st, d};
   endfunction

   function automatic logic [11:0] obs_main();
      return {clr_we, 5'd0, clr_addr, stage_rst_n, init_done};
   endfunction

   function automatic logic [11:0] obs_def();
      return {clr_we_d, clr_addr_d, stage_rst_n_d, init_done_d};
   endfunction

   task automatic check_main(input string tag);
      logic [11:0] exp_v;
      logic [11:0] obs_v;
      exp_v = sb_q.pop_front();
      obs_v = obs_main();
      n_vec++;
      assert (obs_v === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs_v, exp_v, $time);
      end
   endtask

   task automatic check_def(input string tag);
      logic [11:0] exp_v;
      logic [11:0] obs_v;
      exp_v = sb_q.pop_front();
      obs_v = obs_def();
      n_vec++;
      assert (obs_v === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs_v, exp_v, $time);
      end
   endtask

   // Drive soft_init for one edge, predict the main DUT, then compare.
   task automatic step(input logic si, input string tag);
      logic [11:0] cur;
      soft_init = si;
      cur = model(n_m, 2, 4, 3);
      if (!rst_n)                 n_m = 0;
      else if (cur[0] && si)      n_m = 0;
      else if (n_m < 1000)        n_m = n_m + 1;
      sb_q.push_back(rst_n ? model(n_m, 2, 4, 3) : 12'h000);
      @(posedge clk);
      #1;
      check_main(tag);
   endtask

   initial begin
      int we_cnt;
      int done_edge;
      rst_n     = 1'b0;
      rst_d     = 1'b0;
      soft_init = 1'b0;
      soft_d    = 1'b0;
      n_vec     = 0;
      n_err     = 0;
      n_m       = 0;

      #2;
      sb_q.push_back(12'h000);
      check_main("reset_state");
      sb_q.push_back(12'h000);
      check_def("reset_state_def");

      // Boot, then hard reset 1 ns after edge 4 (mid-CLEAR).
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b0, "boot_partial");
      rst_n = 1'b0;
      #1;
      n_m = 0;
      sb_q.push_back(12'h000);
      check_main("async_reset");
      step(1'b1, "reset_over_soft");
      step(1'b0, "reset_held");
      rst_n = 1'b1;

      // Full timeline after re-release; done from edge 8 onward.
      for (int i = 0; i < 10; i++) step(1'b0, "timeline");

      // Single soft_init pulse in DONE.
      step(1'b1, "soft_restart");
      for (int i = 0; i < 10; i++) step(1'b0, "soft_timeline");

      // Restart, then pulses during HOLD, CLEAR and RELEASE must be ignored.
      step(1'b1, "soft_restart2");
      step(1'b1, "ignore_hold");
      step(1'b0, "ignored_seq");
      step(1'b0, "ignored_seq");
      step(1'b1, "ignore_clear");
      step(1'b0, "ignored_seq");
      step(1'b0, "ignored_seq");
      step(1'b1, "ignore_release");
      step(1'b0, "ignored_seq");
      step(1'b0, "ignored_seq");
      step(1'b0, "ignored_seq");

      // soft_init held high: one restart per completed sequence.
      for (int i = 0; i < 30; i++) step(1'b1, "soft_held");
      for (int i = 0; i < 10; i++) step(1'b0, "soft_released");

      // Default-parameter instance: 98 clears, done at edge 104.
      soft_init = 1'b0;
      rst_d     = 1'b1;
      we_cnt    = 0;
      done_edge = 0;
      for (int e = 1; e <= 110; e++) begin
         sb_q.push_back(model(e, 4, 98, 3));
         @(posedge clk);
         #1;
         check_def("default_seq");
         if (clr_we_d) we_cnt++;
         if (init_done_d && done_edge == 0) done_edge = e;
      end
      n_vec++;
      assert (we_cnt === 98)
      else begin
         n_err++;
         $error("FAIL default_clear_count: observed %0d expected 98", we_cnt);
      end
      n_vec++;
      assert (done_edge === 104)
      else begin
         n_err++;
         $error("FAIL default_done_edge: observed %0d expected 104", done_edge);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
